// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for sync_fifo: pointer width and the vendor-macro depth rule.
package sync_fifo_pkg;

  localparam int unsigned MIN_MACRO_DEPTH = 16;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Vendor macro needs a power-of-two depth of at least MIN_MACRO_DEPTH.
  function automatic int unsigned macro_depth(input int unsigned depth);
    int unsigned p2;
    p2 = 32'd1 << $clog2(depth);
    return (p2 < MIN_MACRO_DEPTH) ? MIN_MACRO_DEPTH : p2;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM with a registered read port; the read register doubles as
// the FWFT output stage of sync_fifo.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 72,
  parameter int unsigned DEPTH      = 100,
  parameter int unsigned AW         = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register is reset so rdata is never X; it holds when not reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO with ready/valid handshake and overflow/underflow flags.
// BUILT_IN selects the vendor FIFO macro or a portable inferred-RAM implementation.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 72,
  parameter int unsigned FIFO_DEPTH = 100,
  parameter int unsigned BUILT_IN   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wen,
  output logic                  wready,
  output logic                  werr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  ren,
  output logic                  rvalid,
  output logic                  rerr
);

  // Error flags are common to both storage options.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      werr <= 1'b0;
      rerr <= 1'b0;
    end else begin
      werr <= wen & ~wready;
      rerr <= ren & ~rvalid;
    end
  end

  if (BUILT_IN == 0) begin : g_ram
    localparam int unsigned AW = ptr_width(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = CW + 1;
    localparam logic [AW-1:0] LAST    = AW'(FIFO_DEPTH - 1);
    localparam logic [TW-1:0] DEPTH_C = TW'(FIFO_DEPTH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] ram_count;
    logic          wready_q;
    logic          rvalid_q;
    logic          push_c;
    logic          pop_c;
    logic          load_c;
    logic [TW-1:0] total_next_c;

    // The output stage refills whenever it is empty or being popped.
    always_comb begin
      push_c       = wen & wready_q;
      pop_c        = ren & rvalid_q;
      load_c       = (ram_count != '0) & (~rvalid_q | pop_c);
      total_next_c = TW'(ram_count) + TW'(rvalid_q) + TW'(push_c) - TW'(pop_c);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wptr      <= '0;
        rptr      <= '0;
        ram_count <= '0;
        wready_q  <= 1'b0;
        rvalid_q  <= 1'b0;
      end else begin
        if (push_c) wptr <= (wptr == LAST) ? '0 : wptr + AW'(1);
        if (load_c) rptr <= (rptr == LAST) ? '0 : rptr + AW'(1);
        ram_count <= ram_count + CW'(push_c) - CW'(load_c);
        if (load_c)     rvalid_q <= 1'b1;
        else if (pop_c) rvalid_q <= 1'b0;
        wready_q <= (total_next_c < DEPTH_C);
      end
    end

    sync_fifo_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (FIFO_DEPTH),
      .AW        (AW)
    ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (push_c),
      .waddr(wptr),
      .wdata(wdata),
      .re   (load_c),
      .raddr(rptr),
      .rdata(rdata)
    );

    assign wready = wready_q;
    assign rvalid = rvalid_q;
  end else begin : g_xpm
    localparam int unsigned XD  = macro_depth(FIFO_DEPTH);
    localparam int unsigned XCW = $clog2(XD) + 1;

    logic full;
    logic data_valid;
    logic wr_rst_busy;

    xpm_fifo_sync #(
      .FIFO_MEMORY_TYPE   ("auto"),
      .ECC_MODE           ("no_ecc"),
      .FIFO_WRITE_DEPTH   (XD),
      .WRITE_DATA_WIDTH   (DATA_WIDTH),
      .READ_DATA_WIDTH    (DATA_WIDTH),
      .WR_DATA_COUNT_WIDTH(XCW),
      .RD_DATA_COUNT_WIDTH(XCW),
      .READ_MODE          ("fwft"),
      .FIFO_READ_LATENCY  (0),
      .FULL_RESET_VALUE   (0),
      .USE_ADV_FEATURES   ("1000"),
      .DOUT_RESET_VALUE   ("0"),
      .WAKEUP_TIME        (0)
    ) u_xpm (
      .sleep        (1'b0),
      .rst          (rst),
      .wr_clk       (clk),
      .wr_en        (wen & wready),
      .din          (wdata),
      .full         (full),
      .prog_full    (),
      .wr_data_count(),
      .overflow     (),
      .wr_rst_busy  (wr_rst_busy),
      .almost_full  (),
      .wr_ack       (),
      .rd_en        (ren & rvalid),
      .dout         (rdata),
      .empty        (),
      .prog_empty   (),
      .rd_data_count(),
      .underflow    (),
      .rd_rst_busy  (),
      .almost_empty (),
      .data_valid   (data_valid),
      .injectsbiterr(1'b0),
      .injectdbiterr(1'b0),
      .sbiterr      (),
      .dbiterr      ()
    );

    // Writes are held off until the macro leaves its internal reset.
    assign wready = ~full & ~wr_rst_busy;
    assign rvalid = data_valid;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized self-checking bench for sync_fifo (inferred-RAM mode) against a queue model.
module tb_sync_fifo;

  localparam int unsigned DW    = 72;
  localparam int unsigned DEPTH = 100;
  localparam logic [DW-1:0] BASE = 72'hFF000000FF00AA0000;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          wen   = 1'b0;
  logic          ren   = 1'b0;
  logic          wready, werr, rvalid, rerr;
  logic [DW-1:0] rdata;

  sync_fifo #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .BUILT_IN  (0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wdata (wdata),
    .wen   (wen),
    .wready(wready),
    .werr  (werr),
    .rdata (rdata),
    .ren   (ren),
    .rvalid(rvalid),
    .rerr  (rerr)
  );

  always #5 clk = ~clk;

  // Reference model: contents plus the edge on which each entry was written.
  typedef struct {
    logic [DW-1:0] d;
    int unsigned   e;
  } ent_t;

  ent_t          q[$];
  int unsigned   edge_n     = 0;
  logic          exp_wready = 1'b0;
  logic          exp_rvalid = 1'b0;
  logic          exp_werr   = 1'b0;
  logic          exp_rerr   = 1'b0;
  logic [DW-1:0] exp_rdata  = '0;
  bit            m_push, m_pop;
  bit            started    = 1'b0;
  int            checks     = 0;
  int            errors     = 0;
  int            npop;
  int            wp, rp;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an entry written on edge k is visible at the head from edge k+1 on.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      exp_wready = 1'b0;
      exp_rvalid = 1'b0;
      exp_werr   = 1'b0;
      exp_rerr   = 1'b0;
      exp_rdata  = '0;
    end else begin
      edge_n++;
      m_push   = wen && exp_wready;
      m_pop    = ren && exp_rvalid;
      exp_werr = wen && !exp_wready;
      exp_rerr = ren && !exp_rvalid;
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back('{wdata, edge_n});
      exp_rvalid = (q.size() > 0) && (q[0].e < edge_n);
      if (exp_rvalid) exp_rdata = q[0].d;
      exp_wready = (q.size() < DEPTH);
    end
  end

  // Compare every cycle, half a period away from the active edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk1("wready", wready, exp_wready);
      chk1("rvalid", rvalid, exp_rvalid);
      chk1("werr", werr, exp_werr);
      chk1("rerr", rerr, exp_rerr);
      chkd("rdata", rdata, exp_rdata);
    end
  end

  initial begin
    #1 rst = 1'b1;
    started = 1'b1;
    repeat (10) @(negedge clk);
    chk1("reset_wready", wready, 1'b0);
    chk1("reset_rvalid", rvalid, 1'b0);
    chkd("reset_rdata", rdata, '0);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    // Underflow on the empty FIFO.
    ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    chk1("underflow_rerr", rerr, 1'b1);
    chk1("underflow_rvalid", rvalid, 1'b0);
    @(negedge clk);
    chk1("underflow_rerr_end", rerr, 1'b0);

    // Fill to capacity, then one write too many.
    for (int i = 0; i < DEPTH; i++) begin
      chk1("fill_wready", wready, 1'b1);
      wen   = 1'b1;
      wdata = BASE + DW'(i);
      @(negedge clk);
    end
    chk1("full_wready", wready, 1'b0);
    wdata = BASE + DW'(999);
    @(negedge clk);
    wen = 1'b0;
    chk1("overflow_werr", werr, 1'b1);
    chki("model_full_count", q.size(), DEPTH);
    @(negedge clk);
    chk1("overflow_werr_end", werr, 1'b0);

    // Drain: exactly the 100 written values, in order.
    for (int i = 0; i < DEPTH; i++) begin
      chk1("drain_rvalid", rvalid, 1'b1);
      chkd("drain_rdata", rdata, BASE + DW'(i));
      ren = 1'b1;
      @(negedge clk);
    end
    ren = 1'b0;
    chk1("drained_rvalid", rvalid, 1'b0);
    chk1("drained_rerr", rerr, 1'b0);

    // Advance pointers to 80 so the concurrent phase crosses the wrap.
    for (int i = 0; i < 80; i++) begin
      wen   = 1'b1;
      wdata = DW'({$urandom(), $urandom(), $urandom()});
      @(negedge clk);
    end
    wen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      ren = 1'b1;
      @(negedge clk);
    end
    ren = 1'b0;

    // 50 queued, then 20 cycles of push+pop together.
    for (int i = 0; i < 50; i++) begin
      wen   = 1'b1;
      wdata = DW'({$urandom(), $urandom(), $urandom()});
      @(negedge clk);
    end
    wen = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      wen   = 1'b1;
      ren   = 1'b1;
      wdata = DW'({$urandom(), $urandom(), $urandom()});
      @(negedge clk);
      chki("concurrent_count", q.size(), 50);
      chk1("concurrent_rvalid", rvalid, 1'b1);
    end
    wen  = 1'b0;
    ren  = 1'b0;
    npop = 0;
    for (int k = 0; k < 60; k++) begin
      if (rvalid) npop++;
      ren = 1'b1;
      @(negedge clk);
    end
    ren = 1'b0;
    chki("concurrent_drain_count", npop, 50);

    // Random traffic with alternating fill-heavy and drain-heavy phases.
    for (int p = 0; p < 10; p++) begin
      wp = (p % 2 == 0) ? 80 : 30;
      rp = (p % 2 == 0) ? 30 : 80;
      for (int c = 0; c < 300; c++) begin
        wen   = ($urandom_range(0, 99) < wp);
        ren   = ($urandom_range(0, 99) < rp);
        wdata = DW'({$urandom(), $urandom(), $urandom()});
        @(negedge clk);
      end
    end
    wen = 1'b0;
    ren = 1'b0;

    // Reset mid-stream after 30 writes.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      wen   = 1'b1;
      wdata = BASE + DW'(i);
      @(negedge clk);
    end
    wen = 1'b0;
    chk1("midstream_rvalid_before", rvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("midstream_rvalid_drop", rvalid, 1'b0);
    chk1("midstream_wready_drop", wready, 1'b0);
    chkd("midstream_rdata_clear", rdata, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_reset_wready", wready, 1'b1);
    chk1("post_reset_empty", rvalid, 1'b0);
    wen   = 1'b1;
    wdata = DW'(1);
    @(negedge clk);
    wen = 1'b0;
    chk1("write_latency_rvalid", rvalid, 1'b0);
    @(negedge clk);
    chk1("post_reset_first_rvalid", rvalid, 1'b1);
    chkd("post_reset_first_rdata", rdata, DW'(1));
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock FIFO with first-word-fall-through (FWFT) read semantics, a ready/valid handshake, and overflow/underflow error flags.
- Parameter BUILT_IN selects the storage:
  - 1: wrapper around the vendor synchronous FIFO macro (Xilinx xpm_fifo_sync, FWFT mode).
  - 0: portable inferred-RAM implementation.
- Both modes produce identical read data sequences.
- Used as a generic buffering block between streaming stages.

Parameters:
- DATA_WIDTH, 72, width of wdata/rdata in bits.
- FIFO_DEPTH, 100, minimum number of storable entries; need not be a power of two.
- BUILT_IN, 0, 1 = vendor FIFO macro, 0 = inferred RAM and pointer logic.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wdata  input  DATA_WIDTH  write data.
- wen  input  1  write request.
- wready  output  1  FIFO can accept a write this cycle.
- werr  output  1  overflow: write attempted while wready=0.
- rdata  output  DATA_WIDTH  head-of-FIFO data; valid when rvalid=1.
- ren  input  1  read/pop request.
- rvalid  output  1  rdata holds a valid head entry.
- rerr  output  1  underflow: read attempted while rvalid=0.

Behaviour:
- Reset:
  - While rst=1: wready=0, rvalid=0, werr=0, rerr=0, rdata=0.
  - All contents are flushed and pointers/count cleared.
  - Reset asserted mid-operation discards all data immediately (asynchronous).
- After reset release, wready rises within 1 cycle for BUILT_IN=0 and within 20 cycles for BUILT_IN=1.
- Write: accepted on a rising edge when wen=1 and wready=1; wdata is stored at the tail.
- FWFT read:
  - When rvalid=1, rdata already presents the oldest entry, with no ren needed.
  - ren=1 with rvalid=1 pops that entry at the rising edge; the next entry appears on rdata in the same cycle following the edge.
- Write-to-visible latency:
  - BUILT_IN=0: a write at edge k makes rvalid=1 after edge k+1, i.e. one registered cycle into the empty FIFO.
  - BUILT_IN=1: macro latency, at most 4 cycles.
- Ordering: strict FIFO order; no data duplication or loss.
- Capacity:
  - BUILT_IN=0: exactly FIFO_DEPTH entries; wready=0 when count==FIFO_DEPTH.
  - BUILT_IN=1: the macro depth is FIFO_DEPTH rounded up to a power of two, minimum 16; wready follows the macro full flag.
- Full boundary: a write while wready=0 is dropped, even if ren pops in the same cycle. werr pulses high for exactly one cycle, the cycle after the offending edge.
- Empty boundary: a read while rvalid=0 is ignored. rerr pulses high for one cycle after the offending edge.
- Simultaneous wen and ren with both handshakes valid: one push and one pop; count unchanged.
- Empty FIFO with wen and ren together: the write is accepted and the read flags rerr.
- Inferred implementation:
  - Read and write pointers wrap from FIFO_DEPTH-1 to 0 (modulo, not power-of-two masking).
  - Count width is $clog2(FIFO_DEPTH+1).
  - Storage is a simple dual-port RAM with a registered output prefetch stage to implement FWFT.
- rdata is don't-care-stable when rvalid=0; it holds its last value and must not be X after reset.

Decomposition:
- Package sync_fifo_pkg: function for the pointer width ($clog2(FIFO_DEPTH)) and the constant for minimum macro depth (16).
- One natural sub-module: sync_fifo_ram, the inferred simple dual-port RAM used when BUILT_IN=0.
- BUILT_IN=1 uses a generate branch instantiating xpm_fifo_sync, with wready = !full and rvalid = data_valid.
- The error flags use shared logic for both branches.

Test Plan:
- Parity: instantiate both modes with DATA_WIDTH=72, FIFO_DEPTH=100, using shared stimulus.
- Fill and drain:
  - Stimulus: hold rst 10 cycles, wait 50; write wdata = 72'hFF000000FF00AA0000 + i for i=0..99 on consecutive cycles; idle 1 cycle; then hold ren=1 for 100 cycles.
  - Required: wready=1 throughout the writes; rdata equals 72'hFF000000FF00AA0000 + i at each read cycle; identical rdata from both modes; werr and rerr stay 0.
- Overflow (BUILT_IN=0): 101st write while full -> werr=1 for one cycle, and the entry is not stored; the drain still yields exactly 100 entries.
- Underflow: ren=1 on the empty FIFO after reset -> rerr one-cycle pulse; rvalid stays 0; no pointer movement.
- Concurrent read/write: with 50 entries queued, assert wen and ren together for 20 cycles -> count stays 50; order is preserved across the pointer wrap at index 99→0.
- Reset mid-stream: assert rst after 30 writes -> rvalid and wready drop immediately; after release the FIFO is empty and a new write of 72'h1 reads back as the first entry.
